// File: rtl/native_rr_arbiter.sv
// Round-robin arbiter sharing one native valid/ready slave among N_MASTERS masters, one transaction at a time.
// Optional slave-ready watchdog is enabled by defining NATIVE_ARB_TIMEOUT_EN.
module native_rr_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int GRANT_W    = $clog2(N_MASTERS),
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_MASTERS-1:0]             m_valid,
  output logic [N_MASTERS-1:0]             m_ready,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  input  logic [N_MASTERS*STRB_WIDTH-1:0]  m_wstrb,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             s_valid,
  input  logic                             s_ready,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic [STRB_WIDTH-1:0]            s_wstrb,
  input  logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [GRANT_W-1:0]               grant,
  output logic                             busy,
  output logic                             timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] pick, cand, grant_inc;
  logic               found, gnt_valid, complete, expire;

`ifdef NATIVE_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick  = rr_ptr_q;
    cand  = rr_ptr_q;
    found = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = GRANT_W'((int'(rr_ptr_q) + i) % N_MASTERS);
      if (!found && m_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign grant_inc = (grant_q == GRANT_W'(N_MASTERS - 1)) ? '0 : grant_q + GRANT_W'(1);
  assign gnt_valid = m_valid[grant_q];
  assign complete  = (state_q == BUSY) && gnt_valid && s_ready;

`ifdef NATIVE_ARB_TIMEOUT_EN
  assign expire      = (state_q == BUSY) && gnt_valid && !s_ready && (cnt_q == CNT_W'(TIMEOUT));
  assign timeout_err = timeout_err_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
`ifdef NATIVE_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef NATIVE_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
`ifdef NATIVE_ARB_TIMEOUT_EN
    cnt_d         = '0;
    timeout_err_d = timeout_err_q | expire;
`endif
    case (state_q)
      IDLE: begin
        if (|m_valid) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef NATIVE_ARB_TIMEOUT_EN
        cnt_d = s_ready ? cnt_q : cnt_q + CNT_W'(1);
`endif
        if (complete || expire) begin
          rr_ptr_d = grant_inc;
          state_d  = IDLE;
        end else if (!gnt_valid) begin
          // Owner withdrew without completion: abandon without advancing fairness.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_ready = '0;
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_rdata = s_rdata;
    if (state_q == BUSY && !rst) begin
      s_valid = gnt_valid;
      for (int i = 0; i < N_MASTERS; i++) begin
        if (grant_q == GRANT_W'(i)) begin
          s_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          s_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
          s_wstrb = m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
        end
      end
      m_ready[grant_q] = complete || expire;
      if (expire) m_rdata = '0;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_native_rr_arbiter.sv
// Directed table-driven bench for native_rr_arbiter with two masters.
// Rows are applied on the falling edge and outputs compared 1ns later.
module tb_native_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_valid = '0;
  logic [1:0]  m_ready;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_wstrb = '0;
  logic [31:0] m_rdata;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata = '0;
  logic [0:0]  grant;
  logic        busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int row = 0;

  always #5 clk = ~clk;

  native_rr_arbiter #(
    .N_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  mv;
    logic        sr;
    logic [31:0] rdata;
    logic [31:0] a0, a1, w0, w1;
    logic [3:0]  st0, st1;
    logic        full;
    logic        sv;
    logic [1:0]  mr;
    logic        gr;
    logic        bsy;
    logic [31:0] saddr, swdata;
    logic [3:0]  swstrb;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] p_a0, p_a1, p_w0, p_w1;
  logic [3:0]  p_st0, p_st1;

  function automatic void add(logic r, logic [1:0] mv, logic sr, logic [31:0] rdata, logic full,
                              logic sv, logic [1:0] mr, logic gr, logic bsy,
                              logic [31:0] saddr, logic [31:0] swdata, logic [3:0] swstrb);
    vec_t v;
    v.rst = r; v.mv = mv; v.sr = sr; v.rdata = rdata;
    v.a0 = p_a0; v.a1 = p_a1; v.w0 = p_w0; v.w1 = p_w1; v.st0 = p_st0; v.st1 = p_st1;
    v.full = full; v.sv = sv; v.mr = mr; v.gr = gr; v.bsy = bsy;
    v.saddr = saddr; v.swdata = swdata; v.swstrb = swstrb;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst     = v.rst;
    m_valid = v.mv;
    s_ready = v.sr;
    s_rdata = v.rdata;
    m_addr  = {v.a1, v.a0};
    m_wdata = {v.w1, v.w0};
    m_wstrb = {v.st1, v.st0};
  endtask

  task automatic check_output(input vec_t v);
    check("s_valid", 32'(s_valid), 32'(v.sv));
    check("m_ready", 32'(m_ready), 32'(v.mr));
    check("m_rdata", m_rdata, v.rdata);
    check("timeout_err", 32'(timeout_err), 32'h0);
    if (v.full) begin
      check("grant", 32'(grant), 32'(v.gr));
      check("busy", 32'(busy), 32'(v.bsy));
    end
    if (v.sv) begin
      check("s_addr", s_addr, v.saddr);
      check("s_wdata", s_wdata, v.swdata);
      check("s_wstrb", 32'(s_wstrb), 32'(v.swstrb));
    end
  endtask

  int first_pulse;
  logic [31:0] pulse_rdata;

  initial begin
    // Reset held three cycles; first row is before flops are known to be reset.
    p_a0 = 32'h10; p_w0 = 32'h0; p_st0 = 4'h0;
    p_a1 = 32'h30; p_w1 = 32'h0; p_st1 = 4'h0;
    add(1, 2'b00, 0, 32'h0,        0, 0, 2'b00, 0, 0, 0, 0, 0);
    add(1, 2'b00, 0, 32'h5,        1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(1, 2'b00, 0, 32'h0,        1, 0, 2'b00, 0, 0, 0, 0, 0);
    // Single read from m0, slave answers two cycles after s_valid.
    add(0, 2'b01, 0, 32'h0,        1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b01, 0, 32'h0,        1, 1, 2'b00, 0, 1, 32'h10, 32'h0, 4'h0);
    add(0, 2'b01, 0, 32'h0,        1, 1, 2'b00, 0, 1, 32'h10, 32'h0, 4'h0);
    add(0, 2'b01, 1, 32'hCAFE0001, 1, 1, 2'b01, 0, 1, 32'h10, 32'h0, 4'h0);
    add(0, 2'b00, 0, 32'h0,        1, 0, 2'b00, 0, 0, 0, 0, 0);
    // Reset back to rr_ptr=0, then both masters write continuously.
    add(1, 2'b00, 0, 32'h0,        1, 0, 2'b00, 0, 0, 0, 0, 0);
    p_a0 = 32'h20; p_w0 = 32'hA; p_st0 = 4'hF;
    p_a1 = 32'h24; p_w1 = 32'hB; p_st1 = 4'hF;
    add(0, 2'b11, 0, 32'h0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 1, 32'h0, 1, 1, 2'b01, 0, 1, 32'h20, 32'hA, 4'hF);
    add(0, 2'b11, 0, 32'h0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 1, 32'h0, 1, 1, 2'b10, 1, 1, 32'h24, 32'hB, 4'hF);
    add(0, 2'b11, 0, 32'h0, 1, 0, 2'b00, 1, 0, 0, 0, 0);
    add(0, 2'b11, 0, 32'h0, 1, 1, 2'b00, 0, 1, 32'h20, 32'hA, 4'hF);
    add(0, 2'b11, 1, 32'h0, 1, 1, 2'b01, 0, 1, 32'h20, 32'hA, 4'hF);
    add(0, 2'b00, 0, 32'h0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    // m1 alone, four back-to-back reads; ready while idle must be ignored.
    p_a1 = 32'h30; p_w1 = 32'h0; p_st1 = 4'h0;
    add(0, 2'b10, 1, 32'h1,  1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b10, 1, 32'h11, 1, 1, 2'b10, 1, 1, 32'h30, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      add(0, 2'b10, 0, 32'h0,  1, 0, 2'b00, 1, 0, 0, 0, 0);
      add(0, 2'b10, 1, 32'h22, 1, 1, 2'b10, 1, 1, 32'h30, 32'h0, 4'h0);
    end
    // m0 drops valid mid-transaction: no pulse and rr_ptr stays at 0.
    p_a0 = 32'h40; p_w0 = 32'h55; p_st0 = 4'h3;
    add(0, 2'b01, 0, 32'h0, 1, 0, 2'b00, 1, 0, 0, 0, 0);
    add(0, 2'b00, 1, 32'h0, 1, 0, 2'b00, 0, 1, 0, 0, 0);
    add(0, 2'b11, 0, 32'h0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 1, 32'h0, 1, 1, 2'b01, 0, 1, 32'h40, 32'h55, 4'h3);
    // Reset one cycle into BUSY for m1; afterwards arbitration restarts from m0.
    add(0, 2'b10, 0, 32'h0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b10, 0, 32'h0, 1, 1, 2'b00, 1, 1, 32'h30, 32'h0, 4'h0);
    add(1, 2'b10, 1, 32'h0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 0, 32'h0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 1, 32'h0, 1, 1, 2'b01, 0, 1, 32'h40, 32'h55, 4'h3);
    add(0, 2'b00, 0, 32'h0, 1, 0, 2'b00, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      row = i;
      apply_stimulus(vecs[i]);
      #1;
      check_output(vecs[i]);
    end

    // Slave never answers m0 for 100 cycles.
    row = 999;
    first_pulse = -1;
    pulse_rdata = '1;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst = 1'b0; m_valid = 2'b01; s_ready = 1'b0; s_rdata = 32'hDEAD0000;
      end
      #1;
      if (m_ready != 2'b00 && first_pulse < 0) begin
        first_pulse = i;
        pulse_rdata = m_rdata;
      end
    end
`ifdef NATIVE_ARB_TIMEOUT_EN
    check("timeout_pulse_cycle", 32'(first_pulse), 32'd9);
    check("timeout_rdata", pulse_rdata, 32'h0);
    check("timeout_err_set", 32'(timeout_err), 32'h1);
`else
    check("no_pulse", 32'(first_pulse), 32'hFFFFFFFF);
    check("still_busy", 32'(busy), 32'h1);
    check("no_timeout_err", 32'(timeout_err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
